// File: rtl/sccb_req_arbiter_if.sv
// Requester/sender bundle around the SCCB request arbiter.
// The slave modport is the arbiter's view; master is everything around it.
interface sccb_req_arbiter_if;
  logic        req_a;
  logic [15:0] data_a;
  logic        grant_a;
  logic        done_a;
  logic        req_b;
  logic [15:0] data_b;
  logic        grant_b;
  logic        done_b;
  logic        snd_send;
  logic [7:0]  snd_id;
  logic [15:0] snd_data;
  logic        snd_busy;
  logic        err_timeout;

  modport slave (
    input  req_a, data_a, req_b, data_b, snd_busy,
    output grant_a, done_a, grant_b, done_b, snd_send, snd_id, snd_data, err_timeout
  );

  modport master (
    output req_a, data_a, req_b, data_b, snd_busy,
    input  grant_a, done_a, grant_b, done_b, snd_send, snd_id, snd_data, err_timeout
  );
endinterface

// File: rtl/sccb_req_arbiter.sv
// Two-requester arbiter in front of the single SCCB sender: launch, busy tracking,
// inter-transaction gap and watchdog. Define SCCB_ARB_ROUND_ROBIN_EN for alternating priority.
module sccb_req_arbiter #(
  parameter logic [7:0] SLAVE_ID       = 8'h42,
  parameter int         GAP_CYCLES     = 1000,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  sccb_req_arbiter_if.slave bus
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP
  } state_e;

  state_e        state_q;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          sel_b_q;
  logic          grant_a_q, grant_b_q, done_a_q, done_b_q;
  logic          snd_send_q, err_timeout_q;
  logic [15:0]   snd_data_q;
  logic          pick_b, tmo_hit, xfer_end;

  assign gap_cnt_d = gap_cnt_q + 1'b1;
  assign tmo_cnt_d = tmo_cnt_q + 1'b1;

  assign tmo_hit  = (state_q == WAIT_BUSY || state_q == WAIT_DONE) && (tmo_cnt_q == TMO_LAST);
  assign xfer_end = tmo_hit || (state_q == WAIT_DONE && !bus.snd_busy);

`ifdef SCCB_ARB_ROUND_ROBIN_EN
  // Last-served owner; resets to B so A takes the first tie.
  logic last_b_q;

  assign pick_b = bus.req_b && (!bus.req_a || !last_b_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_b_q <= 1'b1;
    end else if (state_q == IDLE && !bus.snd_busy && (bus.req_a || bus.req_b)) begin
      last_b_q <= pick_b;
    end
  end
`else
  // Only consulted when some request is up, so "not A" means B.
  assign pick_b = !bus.req_a;
`endif

  // NOTE: all state uses non-blocking assignments; the one-cycle strobes default low
  // at the top of the block so later branches only need to raise them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      gap_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      sel_b_q       <= 1'b0;
      grant_a_q     <= 1'b0;
      grant_b_q     <= 1'b0;
      done_a_q      <= 1'b0;
      done_b_q      <= 1'b0;
      snd_send_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      snd_data_q    <= '0;
    end else begin
      snd_send_q <= 1'b0;
      done_a_q   <= 1'b0;
      done_b_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Holding off while busy covers a reset that landed mid-transfer.
          if (!bus.snd_busy && (bus.req_a || bus.req_b)) begin
            state_q    <= LAUNCH;
            snd_send_q <= 1'b1;
            sel_b_q    <= pick_b;
            grant_a_q  <= !pick_b;
            grant_b_q  <= pick_b;
            snd_data_q <= pick_b ? bus.data_b : bus.data_a;
          end
        end
        LAUNCH: begin
          state_q   <= WAIT_BUSY;
          tmo_cnt_q <= '0;
        end
        WAIT_BUSY, WAIT_DONE: begin
          tmo_cnt_q <= tmo_cnt_d;
          if (xfer_end) begin
            state_q       <= GAP;
            gap_cnt_q     <= '0;
            grant_a_q     <= 1'b0;
            grant_b_q     <= 1'b0;
            done_a_q      <= !sel_b_q;
            done_b_q      <= sel_b_q;
            err_timeout_q <= err_timeout_q || tmo_hit;
          end else if (state_q == WAIT_BUSY && bus.snd_busy) begin
            state_q <= WAIT_DONE;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant_a     = grant_a_q;
  assign bus.grant_b     = grant_b_q;
  assign bus.done_a      = done_a_q;
  assign bus.done_b      = done_b_q;
  assign bus.snd_send    = snd_send_q;
  assign bus.snd_id      = SLAVE_ID;
  assign bus.snd_data    = snd_data_q;
  assign bus.err_timeout = err_timeout_q;

endmodule
